// File: rtl/tinycpu_pkg.sv
// Shared constants for the tiny CPU: widths, opcodes, instruction field positions
// and the fetch FSM state type.
package tinycpu_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_LI  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hF;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned DST_MSB  = 11;
  localparam int unsigned DST_LSB  = 9;
  localparam int unsigned SRCA_MSB = 8;
  localparam int unsigned SRCA_LSB = 6;
  localparam int unsigned SRCB_MSB = 5;
  localparam int unsigned SRCB_LSB = 3;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } fetch_state_e;

  function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small {instr, pc} FIFO for the fetch stage. Head outputs come straight from the
// storage registers; flush empties the buffer in one cycle.
module fetch_fifo #(
  parameter int unsigned Depth  = 2,
  parameter int unsigned InstrW = 16,
  parameter int unsigned PcW    = 8,
  parameter int unsigned CntW   = $clog2(Depth) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [InstrW-1:0] instr_i,
  input  logic [PcW-1:0]    pc_i,
  output logic [CntW-1:0]   count_o,
  output logic [InstrW-1:0] head_instr_o,
  output logic [PcW-1:0]    head_pc_o,
  output logic              head_valid_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [InstrW-1:0] instr_q [Depth];
  logic [InstrW-1:0] instr_d [Depth];
  logic [PcW-1:0]    pc_q    [Depth];
  logic [PcW-1:0]    pc_d    [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_pop;

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop_i & (count_q != '0);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        instr_d[wr_ptr_q] = instr_i;
        pc_d[wr_ptr_q]    = pc_i;
        wr_ptr_d          = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q  <= '{default: '0};
      pc_q     <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_instr_o = instr_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM request credit, jump redirect and fetch buffer.
// Optional FETCH_PERF_EN adds a saturating retired-instruction counter.
module fetch_unit #(
  parameter int unsigned   PC_W      = tinycpu_pkg::PC_W,
  parameter int unsigned   INSTR_W   = tinycpu_pkg::INSTR_W,
  parameter int unsigned   BUF_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_target,
  output logic [15:0]        perf_retired
);

  import tinycpu_pkg::*;

  localparam int unsigned    CntW   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CntW:0]  DepthL = (CntW + 1)'(BUF_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   slots_used;
  logic            transfer, jump, push, req;

  always_comb begin
    transfer   = instr_valid & instr_ready;
    jump       = transfer & jump_en;
    // A slot freed by this cycle's pop is reusable, giving one word per cycle.
    slots_used = {1'b0, count} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, transfer};
    req        = (state_q == StRun) & (slots_used < DepthL) & ~jump;
    push       = inflight_q & ~drop_q & ~jump;

    state_d = state_q;
    unique case (state_q)
      StIdle: if (en)  state_d = StRun;
      StRun:  if (!en) state_d = StIdle;
    endcase

    pc_d = pc_q;
    if (jump) begin
      pc_d = jump_target;
    end else if (req) begin
      pc_d = pc_q + PC_W'(1);
    end
    inflight_d = req;
    req_pc_d   = req ? pc_q : req_pc_q;
    // Any response still owed after a redirect belongs to the old stream.
    drop_d     = jump & inflight_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc_q;

  fetch_fifo #(
    .Depth  (BUF_DEPTH),
    .InstrW (INSTR_W),
    .PcW    (PC_W),
    .CntW   (CntW)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .push_i       (push),
    .pop_i        (transfer),
    .flush_i      (jump),
    .instr_i      (imem_rdata),
    .pc_i         (req_pc_q),
    .count_o      (count),
    .head_instr_o (instr),
    .head_pc_o    (instr_pc),
    .head_valid_o (instr_valid)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (transfer && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_retired = perf_q;
`else
  assign perf_retired = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected {instr, pc} deliveries,
// a monitor thread pops and compares on every decode transfer.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_en;
  logic [7:0]  jump_target;
  logic [15:0] perf_retired;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic ready_en = 1'b0;
  logic jmp_on   = 1'b0;
  int   xfer_cnt;
  int   xfer_limit = 0;

`ifdef FETCH_PERF_EN
  localparam bit PerfOn = 1'b1;
`else
  localparam bit PerfOn = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .jump_en      (jump_en),
    .jump_target  (jump_target),
    .perf_retired (perf_retired)
  );

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    if (a == 8'h03) return 16'h90AA;
    return 16'h0298 + {8'h00, a};
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= rom_word(imem_addr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt <= 0;
    else if (instr_valid && instr_ready) xfer_cnt <= xfer_cnt + 1;
  end

  // Decode model: stop accepting after xfer_limit words; JMP at pc 0x03 and 0xAB.
  always_comb begin
    instr_ready = ready_en && (xfer_cnt < xfer_limit);
    jump_en     = jmp_on && instr_valid && ((instr_pc == 8'h03) || (instr_pc == 8'hAB));
    jump_target = (instr_pc == 8'h03) ? 8'hAA : 8'hFE;
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] i, input logic [7:0] p);
    sb_q.push_back({i, p});
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t e;

    fork
      forever begin
        @(negedge clk);
        if (instr_valid && instr_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_unexpected: got pc 0x%0h, expected no transfer", instr_pc);
          end else begin
            e = sb_q.pop_front();
            check("sb_pc", 32'(instr_pc), 32'(e.pc));
            check("sb_instr", 32'(instr), 32'(e.instr));
          end
        end
      end
    join_none

    // Reset state
    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h00);
    check("rst_instr", 32'(instr), 32'h0000);
    check("rst_instr_pc", 32'(instr_pc), 32'h00);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_perf", 32'(perf_retired), 32'd0);
    #4 rst_n = 1'b1;
    tick();

    // Stream, backpressure, jump to 0xAA, jump to 0xFE with wrap
    push_exp(16'h0298, 8'h00);
    push_exp(16'h0299, 8'h01);
    push_exp(16'h029A, 8'h02);
    push_exp(16'h90AA, 8'h03);
    push_exp(16'h0342, 8'hAA);
    push_exp(16'h0343, 8'hAB);
    push_exp(16'h0396, 8'hFE);
    push_exp(16'h0397, 8'hFF);
    push_exp(16'h0298, 8'h00);
    push_exp(16'h0299, 8'h01);
    xfer_limit = 10;
    jmp_on     = 1'b1;
    ready_en   = 1'b1;
    en         = 1'b1;

    k = 0;
    while (!imem_req && k < 20) begin
      tick();
      k++;
    end
    check("first_req", 32'(imem_req), 32'd1);
    check("first_req_addr", 32'(imem_addr), 32'h00);
    tick();
    tick();
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_pc", 32'(instr_pc), 32'h00);
    check("first_instr", 32'(instr), 32'h0298);

    k = 0;
    while (xfer_cnt < 2 && k < 20) begin
      tick();
      k++;
    end
    ready_en = 1'b0;
    check("bp_head_pc", 32'(instr_pc), 32'h02);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stable_pc", 32'(instr_pc), 32'h02);
      check("bp_stable_instr", 32'(instr), 32'h029A);
      check("bp_req_low", 32'(imem_req), 32'd0);
    end
    ready_en = 1'b1;

    k = 0;
    while (!(jump_en && instr_ready) && k < 30) begin
      tick();
      k++;
    end
    check("jmp_seen", 32'(jump_en && instr_ready), 32'd1);
    check("jmp_instr", 32'(instr), 32'h90AA);
    tick();
    check("jmp_gap1", 32'(instr_valid), 32'd0);
    tick();
    check("jmp_gap2", 32'(instr_valid), 32'd0);
    tick();
    check("jmp_target_valid", 32'(instr_valid), 32'd1);
    check("jmp_target_pc", 32'(instr_pc), 32'hAA);

    wait_drain("drain_a");
    repeat (4) tick();
    check("full_head_pc", 32'(instr_pc), 32'h02);
    check("full_req_low", 32'(imem_req), 32'd0);
    check("perf_a", 32'(perf_retired), PerfOn ? 32'd10 : 32'd0);

    // Asynchronous reset pulse between clock edges with the buffer full
    @(posedge clk);
    #3 rst_n = 1'b0;
    xfer_limit = 0;
    #1;
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'h00);
    jmp_on = 1'b0;
    push_exp(16'h0298, 8'h00);
    push_exp(16'h0299, 8'h01);
    push_exp(16'h029A, 8'h02);
    push_exp(16'h90AA, 8'h03);
    xfer_limit = 2;
    #2 rst_n = 1'b1;

    k = 0;
    while (!imem_req && k < 20) begin
      tick();
      k++;
    end
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'h00);

    // en drop with two words queued
    k = 0;
    while (xfer_cnt < 2 && k < 20) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check("queued_req_low", 32'(imem_req), 32'd0);
    check("queued_head_pc", 32'(instr_pc), 32'h02);
    en = 1'b0;
    repeat (3) tick();
    xfer_limit = 4;
    wait_drain("drain_b");
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      check("idle_valid", 32'(instr_valid), 32'd0);
      check("idle_req", 32'(imem_req), 32'd0);
      tick();
    end
    check("perf_b", 32'(perf_retired), PerfOn ? 32'd4 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
